// File: rtl/node_pkg.sv
// Shared types and latency constants for the layer scheduler and its tag pipe.
package node_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } sched_state_t;

    localparam int NODE_LAT = 2;
    localparam int WMEM_LAT = 1;
    localparam int PIPE_LAT = NODE_LAT + WMEM_LAT;

endpackage

// File: rtl/node_sched_tagpipe.sv
// Shift register of {valid, index} tags that follows each weight read through
// memory and node latency so the returning result lands in the right slice.
module node_sched_tagpipe #(
    parameter int DEPTH    = 3,
    parameter int IDX_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [IDX_BITS-1:0] in_index,
    output logic                out_valid,
    output logic [IDX_BITS-1:0] out_index,
    output logic                tail_empty
);

    logic [DEPTH-1:0]    valid_q;
    logic [IDX_BITS-1:0] index_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                index_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            index_q[0] <= in_index;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                index_q[i] <= index_q[i-1];
            end
        end
    end

    // True when only the exit stage may still hold a tag, i.e. the pipe empties next cycle.
    always_comb begin
        tail_empty = !in_valid;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (valid_q[i]) begin
                tail_empty = 1'b0;
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_index = index_q[DEPTH-1];

endmodule

// File: rtl/node_layer_sched.sv
// Time-multiplexes one node across all neurons of a layer.
// Optional performance counters are enabled with `define NODE_SCHED_PERF_EN.
module node_layer_sched
    import node_pkg::*;
#(
    parameter int N_INPUTS    = 16,
    parameter int INPUT_BITS  = 6,
    parameter int WEIGHT_BITS = 6,
    parameter int OUTPUT_BITS = 1,
    parameter int N_NEURONS   = 16,
    parameter int ADDR_BITS   = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [N_INPUTS*INPUT_BITS-1:0]       in_vec,
    output logic                                 busy,
    output logic                                 done,
    output logic [N_NEURONS*OUTPUT_BITS-1:0]     layer_out,
    output logic                                 layer_out_valid,
    output logic                                 w_rd_en,
    output logic [ADDR_BITS-1:0]                 w_addr,
    input  logic [(N_INPUTS+1)*WEIGHT_BITS-1:0]  w_data,
    output logic [N_INPUTS*INPUT_BITS-1:0]       node_inputs,
    output logic [N_INPUTS*WEIGHT_BITS-1:0]      node_weights,
    output logic [WEIGHT_BITS-1:0]               node_bias,
    input  logic [OUTPUT_BITS-1:0]               node_result
`ifdef NODE_SCHED_PERF_EN
    ,
    output logic [31:0]                          perf_cycles,
    output logic [15:0]                          perf_layers
`endif
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N_NEURONS - 1);

    sched_state_t         state, state_n;
    logic [ADDR_BITS-1:0] addr_n;
    logic                 rd_en_n;
    logic                 accept;
    logic                 done_n;
    logic                 exit_valid;
    logic [ADDR_BITS-1:0] exit_index;
    logic                 tail_empty;

    node_sched_tagpipe #(
        .DEPTH    (PIPE_LAT),
        .IDX_BITS (ADDR_BITS)
    ) u_tagpipe (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (w_rd_en),
        .in_index   (w_addr),
        .out_valid  (exit_valid),
        .out_index  (exit_index),
        .tail_empty (tail_empty)
    );

    // done is registered, so it is raised one cycle ahead, as the last tag reaches the exit stage.
    always_comb begin
        state_n = state;
        addr_n  = w_addr;
        rd_en_n = w_rd_en;
        accept  = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = RUN;
                    addr_n  = '0;
                    rd_en_n = 1'b1;
                end
            end
            RUN: begin
                if (w_addr == LAST_ADDR) begin
                    state_n = DRAIN;
                    addr_n  = '0;
                    rd_en_n = 1'b0;
                end else begin
                    addr_n = w_addr + ADDR_BITS'(1);
                end
            end
            DRAIN: begin
                if (done) begin
                    state_n = IDLE;
                end else if (tail_empty) begin
                    done_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            w_addr          <= '0;
            w_rd_en         <= 1'b0;
            done            <= 1'b0;
            layer_out_valid <= 1'b0;
            node_inputs     <= '0;
            layer_out       <= '0;
        end else begin
            state   <= state_n;
            w_addr  <= addr_n;
            w_rd_en <= rd_en_n;
            done    <= done_n;
            if (accept) begin
                node_inputs     <= in_vec;
                layer_out_valid <= 1'b0;
            end else if (done_n) begin
                layer_out_valid <= 1'b1;
            end
            if (exit_valid) begin
                layer_out[int'(exit_index)*OUTPUT_BITS +: OUTPUT_BITS] <= node_result;
            end
        end
    end

    assign busy         = (state != IDLE);
    assign node_weights = w_data[N_INPUTS*WEIGHT_BITS-1:0];
    assign node_bias    = w_data[(N_INPUTS+1)*WEIGHT_BITS-1 -: WEIGHT_BITS];

`ifdef NODE_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= '0;
            perf_layers <= '0;
        end else begin
            if (busy && (perf_cycles != '1)) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (done) begin
                perf_layers <= perf_layers + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_node_layer_sched.sv
// Randomized bench for node_layer_sched with behavioural weight memory, node and layer model.
module tb_node_layer_sched;

    localparam int NI        = 16;
    localparam int IB        = 6;
    localparam int WB        = 6;
    localparam int NN        = 16;
    localparam int AB        = 4;
    localparam int LAT       = 3;
    localparam int LAYER_CYC = NN + LAT + 1;
    localparam int WW        = (NI + 1) * WB;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           start1;
    logic [NI*IB-1:0] in_vec;

    logic           busy, done, layer_out_valid, w_rd_en;
    logic [NN-1:0]  layer_out;
    logic [AB-1:0]  w_addr;
    logic [WW-1:0]  w_data;
    logic [NI*IB-1:0] node_inputs;
    logic [NI*WB-1:0] node_weights;
    logic [WB-1:0]  node_bias;
    logic           node_result;
    logic           nodeStage;

    logic           busy1, done1, valid1, rd1;
    logic [0:0]     layer_out1;
    logic [0:0]     addr1;
    logic [WW-1:0]  w_data1;
    logic [NI*IB-1:0] node_inputs1;
    logic [NI*WB-1:0] node_weights1;
    logic [WB-1:0]  node_bias1;
    logic           node_result1;
    logic           nodeStage1;

`ifdef NODE_SCHED_PERF_EN
    logic [31:0]    perf_cycles, perf_cycles1;
    logic [15:0]    perf_layers, perf_layers1;
`endif

    logic [WW-1:0]  mem [NN];
    logic [WW-1:0]  mem1Word;
    logic [NN-1:0]  prevOut;
    int             errors = 0;
    int             checks = 0;

    always #5 clk = ~clk;

    node_layer_sched dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .in_vec          (in_vec),
        .busy            (busy),
        .done            (done),
        .layer_out       (layer_out),
        .layer_out_valid (layer_out_valid),
        .w_rd_en         (w_rd_en),
        .w_addr          (w_addr),
        .w_data          (w_data),
        .node_inputs     (node_inputs),
        .node_weights    (node_weights),
        .node_bias       (node_bias),
        .node_result     (node_result)
`ifdef NODE_SCHED_PERF_EN
        ,
        .perf_cycles     (perf_cycles),
        .perf_layers     (perf_layers)
`endif
    );

    node_layer_sched #(.N_NEURONS(1), .ADDR_BITS(1)) dut1 (
        .clk             (clk),
        .reset           (reset),
        .start           (start1),
        .in_vec          (in_vec),
        .busy            (busy1),
        .done            (done1),
        .layer_out       (layer_out1),
        .layer_out_valid (valid1),
        .w_rd_en         (rd1),
        .w_addr          (addr1),
        .w_data          (w_data1),
        .node_inputs     (node_inputs1),
        .node_weights    (node_weights1),
        .node_bias       (node_bias1),
        .node_result     (node_result1)
`ifdef NODE_SCHED_PERF_EN
        ,
        .perf_cycles     (perf_cycles1),
        .perf_layers     (perf_layers1)
`endif
    );

    // Neuron function: signed bias plus sum of unsigned inputs times signed weights, output = sum >= 0.
    function automatic logic nodeF(input logic [NI*IB-1:0] inp, input logic [WW-1:0] word);
        int sum;
        sum = int'($signed(word[NI*WB +: WB]));
        for (int i = 0; i < NI; i++) begin
            sum += int'(inp[i*IB +: IB]) * int'($signed(word[i*WB +: WB]));
        end
        return (sum >= 0);
    endfunction

    function automatic logic [WW-1:0] randWord();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[WW-1:0];
    endfunction

    function automatic logic [NN-1:0] modelLayer(input logic [NI*IB-1:0] inp);
        logic [NN-1:0] r;
        for (int k = 0; k < NN; k++) begin
            r[k] = nodeF(inp, mem[k]);
        end
        return r;
    endfunction

    // Neuron k becomes visible in layer_out from cycle k+LAT+2 onward.
    function automatic logic [NN-1:0] mixOut(input logic [NN-1:0] oldV, input logic [NN-1:0] newV, input int c);
        logic [NN-1:0] r;
        for (int k = 0; k < NN; k++) begin
            r[k] = (k + LAT + 2 <= c) ? newV[k] : oldV[k];
        end
        return r;
    endfunction

    // Weight memory: one-cycle read latency, garbage whenever no read is issued.
    always @(posedge clk) begin
        w_data  <= w_rd_en ? mem[w_addr] : randWord();
        w_data1 <= rd1 ? mem1Word : randWord();
    end

    // Node: input register then output register, sharing reset.
    always @(posedge clk) begin
        if (reset) begin
            nodeStage    <= 1'b0;
            node_result  <= 1'b0;
            nodeStage1   <= 1'b0;
            node_result1 <= 1'b0;
        end else begin
            nodeStage    <= nodeF(node_inputs, {node_bias, node_weights});
            node_result  <= nodeStage;
            nodeStage1   <= nodeF(node_inputs1, {node_bias1, node_weights1});
            node_result1 <= nodeStage1;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string where);
        checkOutput({where, "_busy"}, busy, 0);
        checkOutput({where, "_done"}, done, 0);
        checkOutput({where, "_layer_out"}, layer_out, 0);
        checkOutput({where, "_valid"}, layer_out_valid, 0);
        checkOutput({where, "_rd_en"}, w_rd_en, 0);
        checkOutput({where, "_addr"}, w_addr, 0);
        checkOutput({where, "_node_inputs"}, node_inputs, 0);
    endtask

    task automatic applyStimulus(input bit holdStart, input int pulseCycle, input int abortCycle,
                                 input int expAcceptWait, input bit directed);
        logic [NI*IB-1:0] vec;
        logic [NN-1:0]    newOut;
        logic             prevBusy;
        bit               accepted;
        int               waitCount, doneCount, doneCycle, busyCount, rdCount;
        int               addrErr, inErr, validFirst;
        @(negedge clk);
        if (directed) begin
            vec = '1;
            for (int k = 0; k < NN; k++) begin
                mem[k] = '0;
                mem[k][NI*WB +: WB] = (k % 2 == 1) ? 6'sd5 : -6'sd5;
            end
        end else begin
            vec = {$urandom(), $urandom(), $urandom()};
            for (int k = 0; k < NN; k++) begin
                mem[k] = randWord();
            end
        end
        in_vec   = vec;
        start    = 1'b1;
        newOut   = modelLayer(vec);
        prevBusy = busy;
        accepted = 1'b0;
        waitCount = 0;
        while (!accepted && waitCount < 5) begin
            @(posedge clk);
            #1;
            waitCount++;
            if (busy && !prevBusy) accepted = 1'b1;
            prevBusy = busy;
        end
        checkOutput("accept_wait", waitCount, expAcceptWait);
        if (!accepted) begin
            start = 1'b0;
            return;
        end
        checkOutput("valid_drop", layer_out_valid, 0);
        doneCount = 0; doneCycle = 0; busyCount = 0; rdCount = 0;
        addrErr = 0; inErr = 0; validFirst = 0;
        for (int c = 1; c <= LAYER_CYC; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (c == 1 && !holdStart) start = 1'b0;
            if (c == pulseCycle) start = 1'b1;
            if (c == pulseCycle + 1) start = 1'b0;
            if (done) begin
                doneCount++;
                if (doneCycle == 0) doneCycle = c;
            end
            if (busy) busyCount++;
            if (w_rd_en) begin
                rdCount++;
                if (w_addr !== AB'(c - 1)) addrErr++;
            end
            if (node_inputs !== vec) inErr++;
            if (layer_out_valid && validFirst == 0) validFirst = c;
            if (c == 4 || c == 12 || c == LAYER_CYC) begin
                checkOutput($sformatf("layer_out_c%0d", c), layer_out, mixOut(prevOut, newOut, c));
            end
            if (c == abortCycle) begin
                @(negedge clk);
                reset = 1'b1;
                @(posedge clk);
                #1;
                checkResetOutputs("abort");
                @(negedge clk);
                reset   = 1'b0;
                prevOut = '0;
                return;
            end
        end
        checkOutput("done_cycle", doneCycle, LAYER_CYC);
        checkOutput("done_count", doneCount, 1);
        checkOutput("busy_cycles", busyCount, LAYER_CYC);
        checkOutput("rd_count", rdCount, NN);
        checkOutput("addr_seq_errors", addrErr, 0);
        checkOutput("node_inputs_errors", inErr, 0);
        checkOutput("valid_first_cycle", validFirst, LAYER_CYC);
        if (directed) checkOutput("layer_out_aaaa", layer_out, 16'hAAAA);
        prevOut = newOut;
    endtask

    task automatic applySingle();
        logic expBit;
        int   rdCount, doneCycle, busyCount;
        @(negedge clk);
        mem1Word = randWord();
        in_vec   = {$urandom(), $urandom(), $urandom()};
        expBit   = nodeF(in_vec, mem1Word);
        start1   = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        rdCount = 0; doneCycle = 0; busyCount = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (rd1) rdCount++;
            if (busy1) busyCount++;
            if (done1 && doneCycle == 0) doneCycle = c;
            if (c == 5) begin
                checkOutput("n1_layer_out", layer_out1, expBit);
                checkOutput("n1_valid", valid1, 1);
            end
        end
        checkOutput("n1_rd_count", rdCount, 1);
        checkOutput("n1_done_cycle", doneCycle, 5);
        checkOutput("n1_busy_cycles", busyCount, 5);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        start1  = 1'b0;
        in_vec  = '0;
        prevOut = '0;
        mem1Word = '0;
        for (int k = 0; k < NN; k++) mem[k] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkResetOutputs("reset");

        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 2, 0);
        @(posedge clk);
        #1;
`ifdef NODE_SCHED_PERF_EN
        checkOutput("perf_cycles", perf_cycles, 40);
        checkOutput("perf_layers", perf_layers, 2);
`endif

        start = 1'b1;
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 2, 0);
        start = 1'b0;

        applyStimulus(0, 5, 0, 2, 0);
        applyStimulus(0, 0, 8, 2, 0);
        applyStimulus(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 2, 0);
        end

        applySingle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/node_layer_sched.md
# node_layer_sched

Layer scheduler that time-multiplexes one `node` instance across all `N_NEURONS` neurons of a fully-connected layer. On `start` it latches the layer input vector and issues one weight-memory read per cycle, one per neuron. It feeds the returned weights and bias to the node and collects each node result into a per-neuron output register. It sits between the weight ROM/SRAM and the node datapath, and is driven by the network-level controller.

## Interface
- `N_INPUTS`, 16, inputs per neuron
- `INPUT_BITS`, 6, bits per input
- `WEIGHT_BITS`, 6, bits per weight and bias
- `OUTPUT_BITS`, 1, node output width
- `N_NEURONS`, 16, neurons in the layer (≥1)
- `ADDR_BITS`, 4, weight address width (2^ADDR_BITS ≥ N_NEURONS)

Ports:
- `clk` in 1: sole clock
- `reset` in 1: synchronous, active-high
- `start` in 1: begin layer; sampled only in IDLE
- `in_vec` in N_INPUTS*INPUT_BITS: layer inputs, captured when start is accepted
- `busy` out 1: high from the cycle after acceptance until done
- `done` out 1: one-cycle pulse after the last result is written
- `layer_out` out N_NEURONS*OUTPUT_BITS: slice k = result of neuron k
- `layer_out_valid` out 1: set with done, cleared on next accepted start
- `w_rd_en` out 1: weight-memory read strobe
- `w_addr` out ADDR_BITS: neuron index being read
- `w_data` in (N_INPUTS+1)*WEIGHT_BITS: {bias, weights}, valid exactly 1 cycle after w_rd_en
- `node_inputs` out N_INPUTS*INPUT_BITS: registered copy of in_vec
- `node_weights` out N_INPUTS*WEIGHT_BITS: w_data weight field, combinational pass-through
- `node_bias` out WEIGHT_BITS: w_data top field, pass-through
- `node_result` in OUTPUT_BITS: node `outputs_t`

## Operation
- States:
  - IDLE: `start` → RUN, and capture `in_vec`.
  - RUN: issue addresses 0…N_NEURONS-1, one per cycle with `w_rd_en=1`; after issuing N_NEURONS-1, go to DRAIN.
  - DRAIN: wait until the tag pipe is empty; then assert `done`, set `layer_out_valid`, and go to IDLE.
- Pipeline latency from issue to result (PIPE_LAT) is 3:
  - 1 cycle of memory read.
  - 2 cycles inside the node (input register, then output register).
- A PIPE_LAT-deep tag pipe of {valid, index} tracks each issue. When a tag exits valid, `node_result` is written into slice `index` of `layer_out`.
- `start` in RUN or DRAIN is ignored; no queuing.
- `start` together with `reset`: reset wins.
- `layer_out` slices not yet rewritten keep the previous layer's values until overwritten.
- `N_NEURONS=1`: RUN lasts exactly one cycle.
- Reset mid-layer:
  - State goes to IDLE and tag valids clear.
  - `layer_out`, `layer_out_valid`, `busy`, `done`, `w_rd_en`, `w_addr`, and `node_inputs` all go to 0.
  - The node shares `reset`, so no stale result is captured.

## Timing
- `start` accepted at edge E0.
- Cycles 1…N_NEURONS: `w_rd_en=1`, `w_addr=cycle-1`.
- Result for neuron k is captured at the end of cycle k+1+PIPE_LAT.
- `done` and `layer_out_valid` rise in cycle N_NEURONS+PIPE_LAT+1 (20 for defaults).
- `busy` is high in cycles 1…N_NEURONS+PIPE_LAT+1 inclusive; a new `start` is accepted in the cycle after `done`.
- Throughput: one neuron per cycle. Layer time is N_NEURONS+PIPE_LAT+1 cycles.
- `node_inputs` is stable from cycle 1 through `done`.

## Configuration
- `NODE_SCHED_PERF_EN` defined adds two outputs, both cleared by reset:
  - `perf_cycles` [31:0]: counts cycles with `busy`, saturating.
  - `perf_layers` [15:0]: increments on `done`, wrapping.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package `node_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN);
  - constants `NODE_LAT=2`, `WMEM_LAT=1`, and `PIPE_LAT=NODE_LAT+WMEM_LAT`.
- One sub-module, `node_sched_tagpipe`:
  - parameterised shift register of {valid, index}, depth PIPE_LAT, synchronous clear;
  - outputs the exit tag.
- The FSM, address counter and output register file stay in the top module.

## Test plan
- Defaults: `start` with `in_vec=all 1`, memory model returning neuron k's bias sign = k odd. Expect `layer_out=16'hAAAA` (or the golden value from the node model), `done` in cycle 20 only, `busy` cycles 1–20.
- Back-to-back layers:
  - `start` held high continuously → second layer accepted the cycle after the first `done`;
  - `layer_out_valid` drops on acceptance;
  - second `done` 20 cycles later.
- `start` pulsed in cycle 5 of RUN → ignored; `w_addr` sequence 0…15 unbroken; exactly one `done`.
- `reset` asserted in cycle 8 → next cycle all outputs 0 and state IDLE. A fresh `start` then completes normally with no results from the aborted layer.
- `N_NEURONS=1` → one `w_rd_en` cycle, `done` in cycle 5.
- With `NODE_SCHED_PERF_EN` → after two layers, `perf_cycles=40` and `perf_layers=2`.
